// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings and helpers for the mc_datapath_hs multicycle datapath.
// Holds the controller-facing mux/ALU/immediate encodings and the memory FSM state type.
package dp_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;
    localparam logic [2:0] ALU_SLL  = 3'd7;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_REG   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_WIDTH = 2'd2;
    localparam logic [1:0] SRCB_ZERO  = 2'd3;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MDR    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_IMM    = 2'd3;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

    // Number of bytes in one datapath word (PC increment, alignment granule).
    function automatic int unsigned xlen_bytes(input int unsigned xlen);
        return xlen / 32'd8;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// dp_alu: XLEN-wide ALU with zero/negative flags derived from the result.
module dp_alu import dp_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] y,
    output logic            zero,
    output logic            negative
);
    localparam int SHW = $clog2(XLEN);

    // Operation select; shifts use only the low log2(XLEN) bits of b
    always_comb begin
        y = '0;
        case (ctrl)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = ($signed(a) < $signed(b)) ? XLEN'(1'b1) : '0;
            ALU_SLTU: y = (a < b) ? XLEN'(1'b1) : '0;
            ALU_SLL:  y = a << b[SHW-1:0];
            default:  y = '0;
        endcase
    end

    assign zero     = (y == '0);
    assign negative = y[XLEN-1];
endmodule

// File: rtl/dp_imm_ext.sv
// dp_imm_ext: RISC-V immediate decoder, sign-extended to XLEN.
module dp_imm_ext import dp_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm
);
    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate for the selected instruction format
    always_comb begin
        imm32_s = 32'd0;
        case (imm_src)
            IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32_s = {instr[31:12], 12'd0};
            IMM_J:   imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));
endmodule

// File: rtl/dp_mem_if.sv
// dp_mem_if: req/gnt/rvalid memory handshake FSM (IDLE -> REQ -> [WAIT] -> IDLE).
// Latches address, write data, access type and IR-load flag when a start is accepted,
// and generates the one-cycle done and misalign pulses.
// Build option: DP_MISALIGN_CHK_EN rejects starts whose address is not word aligned.
module dp_mem_if import dp_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_start,
    input  logic            mem_write,
    input  logic            ir_write,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic            gnt,
    input  logic            rvalid,
    output logic            accept,
    output logic            rd_done,
    output logic            ir_load,
    output logic            busy,
    output logic            done,
    output logic            misalign,
    output logic            req,
    output logic            we,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] wdata
);
    mem_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic            we_q, we_d, ir_load_q, ir_load_d;
    logic            req_q, req_d, busy_q, busy_d;
    logic            done_q, done_d, misalign_q, misalign_d;
    logic            misaligned_s;

`ifdef DP_MISALIGN_CHK_EN
    localparam int OFFW = $clog2(xlen_bytes(XLEN));
    assign misaligned_s = |addr_in[OFFW-1:0];
`else
    assign misaligned_s = 1'b0;
`endif

    // Next-state and pulse generation for the handshake
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        ir_load_d  = ir_load_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        accept     = 1'b0;
        rd_done    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_start && misaligned_s) begin
                    misalign_d = 1'b1;
                end else if (mem_start) begin
                    accept    = 1'b1;
                    addr_d    = addr_in;
                    wdata_d   = wdata_in;
                    we_d      = mem_write;
                    ir_load_d = ir_write;
                    state_d   = MEM_REQ;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_REQ: begin
                if (gnt && we_q) begin
                    done_d  = 1'b1;
                    state_d = MEM_IDLE;
                end else if (gnt && rvalid) begin
                    done_d  = 1'b1;
                    rd_done = 1'b1;
                    state_d = MEM_IDLE;
                end else if (gnt) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (rvalid) begin
                    done_d  = 1'b1;
                    rd_done = 1'b1;
                    state_d = MEM_IDLE;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
        req_d  = (state_d == MEM_REQ);
        busy_d = (state_d != MEM_IDLE);
    end

    // FSM state and registered bus/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ir_load_q  <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            ir_load_q  <= ir_load_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    assign ir_load  = ir_load_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign misalign = misalign_q;
    assign req      = req_q;
    assign we       = we_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
endmodule

// File: rtl/dp_regfile.sv
// dp_regfile: NREG x XLEN register file, two combinational reads, one synchronous write.
// x0 reads as zero and ignores writes; index bits above log2(NREG) are dropped.
module dp_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] rf_q [NREG];
    logic [AW-1:0]   ra1_s, ra2_s, wa_s;

    assign ra1_s = ra1[AW-1:0];
    assign ra2_s = ra2[AW-1:0];
    assign wa_s  = wa[AW-1:0];

    assign rd1 = (ra1_s == '0) ? '0 : rf_q[ra1_s];
    assign rd2 = (ra2_s == '0) ? '0 : rf_q[ra2_s];

    // Register storage: async clear, synchronous write, x0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we && (wa_s != '0)) begin
            rf_q[wa_s] <= wd;
        end
    end
endmodule

// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs: multicycle RISC-V datapath with a stall-capable req/gnt/rvalid memory port.
// Holds PC, OldPC, IR, MDR, A, B, ALUOut, register file, immediate extender and ALU.
// Build option: DP_MISALIGN_CHK_EN enables misaligned-address rejection in dp_mem_if.
module mc_datapath_hs import dp_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite,
    input  logic            PCWrite,
    input  logic            IRWrite,
    input  logic [2:0]      ImmSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic            AdrSrc,
    input  logic [2:0]      ALUControl,
    input  logic            MemStart,
    input  logic            MemWrite,
    output logic            mem_busy,
    output logic            mem_done,
    output logic            misalign,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            zero,
    output logic            negative
);
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(xlen_bytes(XLEN));

    logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, mdr_q, mdr_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] rd1_s, rd2_s, imm_s, srca_s, srcb_s, alu_y_s, result_s, adr_s;
    logic            accept_s, rd_done_s, ir_load_s;

    dp_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk(clk), .rst_n(rst), .we(RegWrite),
        .ra1(ir_q[19:15]), .ra2(ir_q[24:20]), .wa(ir_q[11:7]),
        .wd(result_s), .rd1(rd1_s), .rd2(rd2_s)
    );

    dp_imm_ext #(.XLEN(XLEN)) u_imm (
        .instr(ir_q[31:7]), .imm_src(ImmSrc), .imm(imm_s)
    );

    dp_alu #(.XLEN(XLEN)) u_alu (
        .a(srca_s), .b(srcb_s), .ctrl(ALUControl),
        .y(alu_y_s), .zero(zero), .negative(negative)
    );

    dp_mem_if #(.XLEN(XLEN)) u_mem (
        .clk(clk), .rst_n(rst),
        .mem_start(MemStart), .mem_write(MemWrite), .ir_write(IRWrite),
        .addr_in(adr_s), .wdata_in(b_q),
        .gnt(mem_gnt), .rvalid(mem_rvalid),
        .accept(accept_s), .rd_done(rd_done_s), .ir_load(ir_load_s),
        .busy(mem_busy), .done(mem_done), .misalign(misalign),
        .req(mem_req), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata)
    );

    // ALU operand and result selection
    always_comb begin
        srca_s   = '0;
        srcb_s   = '0;
        result_s = '0;
        case (ALUSrcA)
            SRCA_PC:    srca_s = pc_q;
            SRCA_OLDPC: srca_s = oldpc_q;
            SRCA_REG:   srca_s = a_q;
            SRCA_ZERO:  srca_s = '0;
            default:    srca_s = '0;
        endcase
        case (ALUSrcB)
            SRCB_REG:   srcb_s = b_q;
            SRCB_IMM:   srcb_s = imm_s;
            SRCB_WIDTH: srcb_s = WORD_BYTES;
            SRCB_ZERO:  srcb_s = '0;
            default:    srcb_s = '0;
        endcase
        case (ResultSrc)
            RES_ALUOUT: result_s = aluout_q;
            RES_MDR:    result_s = mdr_q;
            RES_ALU:    result_s = alu_y_s;
            RES_IMM:    result_s = imm_s;
            default:    result_s = '0;
        endcase
    end

    assign adr_s = AdrSrc ? result_s : pc_q;

    // Next-state for the architectural datapath registers
    always_comb begin
        a_d      = rd1_s;
        b_d      = rd2_s;
        aluout_d = alu_y_s;
        if (PCWrite) begin
            pc_d = result_s;
        end else begin
            pc_d = pc_q;
        end
        if (accept_s && IRWrite) begin
            oldpc_d = pc_q;
        end else begin
            oldpc_d = oldpc_q;
        end
        if (rd_done_s) begin
            mdr_d = mem_rdata;
        end else begin
            mdr_d = mdr_q;
        end
        if (rd_done_s && ir_load_s) begin
            ir_d = mem_rdata[31:0];
        end else begin
            ir_d = ir_q;
        end
    end

    // Datapath registers: async clear, PC to RESET_PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            ir_q     <= 32'd0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    assign opcode = ir_q[6:0];
    assign func3  = ir_q[14:12];
    assign func7  = ir_q[31:25];
endmodule
